data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Word-organised data memory that acts as the responder for the pipeline's memory-stage load/store requests. It accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, then returns one response per request: read data, or an acknowledge for a write. It sits behind the memory stage and lets the pipeline model multi-cycle memory. Its busy output is the stall source for the hazard logic.

Parameters:
DEPTH, 256, number of 16-bit words stored (must be ≥1 and ≤32768)
WAIT_CYCLES, 2, wait states inserted between acceptance and response (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  16  byte address; word index = req_addr[15:1]
req_wdata  input  16  store data
resp_valid  output  1  response valid; asserted for exactly one cycle per accepted request
resp_rdata  output  16  load data; 0 for writes and errors
resp_err  output  1  qualifies resp_valid: misaligned or out-of-range access
busy  output  1  1 whenever state ≠ IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State → IDLE.
  - resp_valid=0, resp_rdata=0x0000, resp_err=0, busy=0, wait counter=0.
  - Memory array contents are NOT cleared by reset.
- req_ready = (state==IDLE), combinational. It is 0 while reset is asserted.
- Acceptance occurs on a rising edge where req_valid && req_ready. At that edge the block latches req_write, req_addr and req_wdata. Later changes on the req_* inputs are ignored until the next acceptance.
- FSM states: IDLE, WAIT, RESP.
  - IDLE → RESP on acceptance if WAIT_CYCLES==0.
  - IDLE → WAIT on acceptance otherwise, loading counter = WAIT_CYCLES−1.
  - WAIT: if counter==0 → RESP, else counter decrements by 1.
  - RESP → IDLE unconditionally on the next edge. There is no back-pressure on the response; the requester must accept it.
- Actions on the edge that enters RESP:
  - err = latched addr[0] | (latched addr[15:1] ≥ DEPTH).
  - Read, err=0: resp_rdata = mem[word index].
  - Write, err=0: mem[word index] = latched wdata; resp_rdata = 0.
  - err=1: no memory write; resp_rdata = 0; resp_err = 1.
- resp_valid, resp_err and resp_rdata are registered. They are valid only while state==RESP.
  - On leaving RESP: resp_valid → 0 and resp_err → 0.
  - resp_rdata holds its last value.
- Timing:
  - Latency = WAIT_CYCLES+1 cycles from the request cycle to the resp_valid cycle.
  - Maximum throughput = one request per WAIT_CYCLES+2 cycles.
  - req_ready rises in the cycle after resp_valid.
- Back-to-back requests: a request held with req_valid=1 through RESP is accepted on the first edge where state==IDLE. It is never accepted during WAIT or RESP.
- Address wrap: none. Addresses ≥ 2·DEPTH flag an error and do not alias.
- Reset mid-operation:
  - If reset asserts before the RESP-entry edge, the pending request is dropped, with no write and no response.
  - If reset asserts during RESP, a write already performed persists.
- A read of a word never written returns X in simulation. The bench initialises the words it reads.

Test Plan:
- WAIT_CYCLES=2. Write addr 0x0040 data 0xBEEF, then read 0x0040.
  - Write: resp_valid 3 cycles after the request cycle, resp_err=0, resp_rdata=0.
  - Read: resp_rdata=0xBEEF with the same 3-cycle latency.
- WAIT_CYCLES=0. Read 0x0002 after mem[1]=0x1234 → resp_valid the next cycle with 0x1234; req_ready=0 in the RESP cycle only.
- Misaligned write 0x0041 data 0xAAAA → resp_err=1, resp_rdata=0; a subsequent read of 0x0040 still returns the old value.
- DEPTH=256. Read 0x0200 → resp_err=1; read 0x01FE → resp_err=0.
- req_valid held high for 3 reads (0x0000, 0x0002, 0x0004) with WAIT_CYCLES=1 → exactly 3 resp_valid pulses, 3 cycles apart, with the correct data; busy never drops between them except for the IDLE cycles.
- Write 0x0010 data 0x5555, with reset pulsed low during WAIT → no response, outputs return to 0 immediately (asynchronous); a later read of 0x0010 returns the value written before the test, not 0x5555.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-organised data memory responding to load/store requests after fixed wait states
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int          ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_W   = 16'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  waitCnt;
    logic        latWrite;
    logic [15:0] latAddr;
    logic [15:0] latWdata;
    logic [15:0] mem [DEPTH];

    logic        accept;
    logic        enterResp;
    logic        curWrite;
    logic [15:0] curAddr;
    logic [15:0] curWdata;
    logic        curErr;
    logic [ADDR_W-1:0] wordIdx;

    assign req_ready = (state == IDLE) && reset;
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // With zero wait states the response is formed on the accepting edge,
    // so the live request fields stand in for the not-yet-latched copies.
    assign curWrite  = (state == IDLE) ? req_write : latWrite;
    assign curAddr   = (state == IDLE) ? req_addr  : latAddr;
    assign curWdata  = (state == IDLE) ? req_wdata : latWdata;
    assign curErr    = curAddr[0] | ({1'b0, curAddr[15:1]} >= DEPTH_W);
    assign wordIdx   = curAddr[ADDR_W:1];

    assign enterResp = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (waitCnt == 4'd0));

    // Storage has no reset; enterResp is already low while reset holds state in IDLE.
    always_ff @(posedge clk) begin
        if (enterResp && curWrite && !curErr) begin
            mem[wordIdx] <= curWdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            waitCnt    <= 4'd0;
            latWrite   <= 1'b0;
            latAddr    <= 16'h0000;
            latWdata   <= 16'h0000;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        latWrite <= req_write;
                        latAddr  <= req_addr;
                        latWdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state   <= WAIT;
                            waitCnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (enterResp) begin
                resp_valid <= 1'b1;
                resp_err   <= curErr;
                resp_rdata <= (!curWrite && !curErr) ? mem[wordIdx] : 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed checks of data_mem_responder at 2, 0 and 1 wait states
module tb_data_mem_responder;

    logic        clk;
    logic [2:0]  rstN;
    logic [2:0]  reqValid;
    logic [2:0]  reqReady;
    logic [2:0]  reqWrite;
    logic [15:0] reqAddr   [3];
    logic [15:0] reqWdata  [3];
    logic [2:0]  respValid;
    logic [15:0] respRdata [3];
    logic [2:0]  respErr;
    logic [2:0]  busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Instance 0: WAIT_CYCLES=2, instance 1: WAIT_CYCLES=0, instance 2: WAIT_CYCLES=1
    for (genvar g = 0; g < 3; g++) begin : gDut
        data_mem_responder #(
            .DEPTH      (256),
            .WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 0 : 1))
        ) dut (
            .clk       (clk),
            .reset     (rstN[g]),
            .req_valid (reqValid[g]),
            .req_ready (reqReady[g]),
            .req_write (reqWrite[g]),
            .req_addr  (reqAddr[g]),
            .req_wdata (reqWdata[g]),
            .resp_valid(respValid[g]),
            .resp_rdata(respRdata[g]),
            .resp_err  (respErr[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request; scrambles the inputs after acceptance so latching is exercised.
    task automatic doReq(input int d, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, input int expLat,
                         input logic expErr, input logic [15:0] expData, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_ready_before"}, 32'(reqReady[d]), 32'd1);
        reqValid[d] = 1'b1;
        reqWrite[d] = wr;
        reqAddr[d]  = addr;
        reqWdata[d] = data;
        @(posedge clk);
        #1;
        reqValid[d] = 1'b0;
        reqWrite[d] = ~wr;
        reqAddr[d]  = ~addr;
        reqWdata[d] = ~data;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!respValid[d] && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'(expLat));
        chk({tag, "_err"}, 32'(respErr[d]), 32'(expErr));
        chk({tag, "_rdata"}, 32'(respRdata[d]), 32'(expData));
        chk({tag, "_ready_in_resp"}, 32'(reqReady[d]), 32'd0);
        @(negedge clk);
        chk({tag, "_valid_drops"}, 32'(respValid[d]), 32'd0);
        chk({tag, "_ready_after"}, 32'(reqReady[d]), 32'd1);
    endtask

    logic [15:0] b2bAddr [3];
    logic [15:0] b2bData [3];
    int nAcc, nResp, lastPulse, idleCnt, cyc;
    int gap;
    logic seenPulse;

    initial begin
        b2bAddr = '{16'h0000, 16'h0002, 16'h0004};
        b2bData = '{16'h0A0A, 16'h0B0B, 16'h0C0C};
        rstN     = 3'b000;
        reqValid = 3'b000;
        reqWrite = 3'b000;
        for (int i = 0; i < 3; i++) begin
            reqAddr[i]  = 16'h0000;
            reqWdata[i] = 16'h0000;
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(reqReady), 32'd0);
        chk("rst_valid", 32'(respValid), 32'd0);
        chk("rst_err", 32'(respErr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata0", 32'(respRdata[0]), 32'd0);
        rstN = 3'b111;
        @(negedge clk);
        chk("ready_after_rst", 32'(reqReady), 32'h7);

        // WAIT_CYCLES=2
        doReq(0, 1'b1, 16'h0040, 16'hBEEF, 3, 1'b0, 16'h0000, "w2_write40");
        doReq(0, 1'b0, 16'h0040, 16'h0000, 3, 1'b0, 16'hBEEF, "w2_read40");
        doReq(0, 1'b1, 16'h0041, 16'hAAAA, 3, 1'b1, 16'h0000, "w2_misaligned");
        doReq(0, 1'b0, 16'h0040, 16'h0000, 3, 1'b0, 16'hBEEF, "w2_read40_again");
        doReq(0, 1'b1, 16'h01FE, 16'h7777, 3, 1'b0, 16'h0000, "w2_write1fe");
        doReq(0, 1'b0, 16'h0200, 16'h0000, 3, 1'b1, 16'h0000, "w2_read200_oor");
        doReq(0, 1'b0, 16'h01FE, 16'h0000, 3, 1'b0, 16'h7777, "w2_read1fe");

        // WAIT_CYCLES=0
        doReq(1, 1'b1, 16'h0002, 16'h1234, 1, 1'b0, 16'h0000, "w0_write2");
        doReq(1, 1'b0, 16'h0002, 16'h0000, 1, 1'b0, 16'h1234, "w0_read2");

        // WAIT_CYCLES=1, back-to-back reads with req_valid held high
        for (int i = 0; i < 3; i++)
            doReq(2, 1'b1, b2bAddr[i], b2bData[i], 2, 1'b0, 16'h0000, "w1_prewrite");
        nAcc = 0; nResp = 0; lastPulse = 0; idleCnt = 0; seenPulse = 1'b0;
        reqWrite[2] = 1'b0;
        for (cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (respValid[2]) begin
                if (nResp < 3) chk("b2b_data", 32'(respRdata[2]), 32'(b2bData[nResp]));
                if (seenPulse) begin
                    gap = cyc - lastPulse;
                    chk("b2b_gap", 32'(gap), 32'd3);
                end
                seenPulse = 1'b1;
                lastPulse = cyc;
                nResp++;
            end else if (seenPulse && nResp < 3 && !busy[2]) begin
                idleCnt++;
            end
            if (reqReady[2]) begin
                if (nAcc < 3) begin
                    reqValid[2] = 1'b1;
                    reqAddr[2]  = b2bAddr[nAcc];
                    nAcc++;
                end else begin
                    reqValid[2] = 1'b0;
                end
            end
        end
        reqValid[2] = 1'b0;
        chk("b2b_pulses", 32'(nResp), 32'd3);
        chk("b2b_idle_cycles", 32'(idleCnt), 32'd2);

        // Reset during WAIT drops the pending write
        doReq(0, 1'b1, 16'h0010, 16'h1111, 3, 1'b0, 16'h0000, "rst_prewrite");
        doReq(0, 1'b0, 16'h0010, 16'h0000, 3, 1'b0, 16'h1111, "rst_preread");
        @(negedge clk);
        reqValid[0] = 1'b1;
        reqWrite[0] = 1'b1;
        reqAddr[0]  = 16'h0010;
        reqWdata[0] = 16'h5555;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy[0]), 32'd1);
        #1;
        rstN[0] = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        chk("midrst_rdata", 32'(respRdata[0]), 32'd0);
        chk("midrst_ready", 32'(reqReady[0]), 32'd0);
        nResp = 0;
        repeat (4) begin
            @(negedge clk);
            if (respValid[0]) nResp++;
        end
        rstN[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (respValid[0]) nResp++;
        end
        chk("midrst_no_resp", 32'(nResp), 32'd0);
        doReq(0, 1'b0, 16'h0010, 16'h0000, 3, 1'b0, 16'h1111, "midrst_read10");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
